// File: rtl/regfile_arb_pkg.sv
// Shared types for the regfile write-port arbiter: queued write request and x0 constant.
package regfile_arb_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  function automatic logic [31:0] addr_onehot(input logic [4:0] addr);
    addr_onehot = 32'd1 << addr;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO of write requests; exposes per-slot valid bits and addresses
// so the owner can build a pending-register mask.
module sync_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wr_req_t               push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wr_req_t               head,
  output logic [DEPTH-1:0]      valid,
  output logic [DEPTH-1:0][4:0] addrs
);

  localparam int PTR_W = $clog2(DEPTH);

  wr_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] valid_next;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_addrs
    assign addrs[i] = mem[i].addr;
  end

  // A simultaneous push into the slot being popped (full FIFO) must leave it valid.
  always_comb begin
    valid_next = valid;
    if (pop)  valid_next[rd_ptr] = 1'b0;
    if (push) valid_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      valid <= valid_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between pipeline WB (always wins) and a queued long-latency unit.
// Define REGFILE_ARB_BYPASS_EN to let a long-latency result use an idle slot directly when the queue is empty.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_wren_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic        ll_valid_i,
  output logic        ll_ready_o,
  input  logic [4:0]  ll_addr_i,
  input  logic [31:0] ll_data_i,
  output logic        rd_wren_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        stall_o,
  output logic [31:0] pend_mask_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  slot_free;
  logic                  pop;
  logic                  push;
  logic                  bypass;
  wr_req_t               head;
  wr_req_t               ll_req;
  logic [DEPTH-1:0]      valid;
  logic [DEPTH-1:0][4:0] addrs;
  logic [WAIT_W-1:0]     wait_cnt;

  assign ll_req    = '{addr: ll_addr_i, data: ll_data_i};
  assign slot_free = !(wb_wren_i && wb_addr_i != REG_X0);
  assign pop       = slot_free && !fifo_empty;

`ifdef REGFILE_ARB_BYPASS_EN
  assign bypass     = slot_free && fifo_empty && ll_valid_i && ll_addr_i != REG_X0;
  assign ll_ready_o = !fifo_full || slot_free;
`else
  assign bypass     = 1'b0;
  assign ll_ready_o = !fifo_full;
`endif

  // x0 results complete the handshake but are dropped here.
  assign push = ll_valid_i && ll_ready_o && ll_addr_i != REG_X0 && !bypass;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push),
    .push_data (ll_req),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .valid     (valid),
    .addrs     (addrs)
  );

  // Address 0 doubles as "no write" so rd_wren_o can never target x0.
  always_comb begin
    rd_addr_o = REG_X0;
    rd_data_o = '0;
    if (!slot_free) begin
      rd_addr_o = wb_addr_i;
      rd_data_o = wb_data_i;
    end else if (!fifo_empty) begin
      rd_addr_o = head.addr;
      rd_data_o = head.data;
    end else if (bypass) begin
      rd_addr_o = ll_addr_i;
      rd_data_o = ll_data_i;
    end
  end

  assign rd_wren_o = (rd_addr_o != REG_X0);

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pend_mask_o = pend_mask_o | addr_onehot(addrs[i]);
    end
  end

  // A non-empty queue that does not pop this cycle was blocked by WB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
      stall_o  <= 1'b0;
    end else begin
      if (pop || fifo_empty) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (pop) begin
        stall_o <= 1'b0;
      end else if (!fifo_empty && wait_cnt >= WAIT_W'(MAX_WAIT - 1)) begin
        stall_o <= 1'b1;
      end
    end
  end

  a_wb_honours_stall: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (stall_o && $past(stall_o)) |-> !(wb_wren_i && wb_addr_i != REG_X0)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: vector table, queue-based scoreboard and
// hand-written stall, x0, reset and bypass sequences.
module tb_regfile_wr_arbiter;
  import regfile_arb_pkg::*;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
`ifdef REGFILE_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_wren;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        stall;
  logic [31:0] pend_mask;

  int n_checks = 0;
  int n_fail   = 0;

  wr_req_t model_q[$];
  int      model_wait;
  bit      model_stall;

  typedef struct {
    bit          wb_wren;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    bit          ll_valid;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    bit          exp_wren;
    logic [4:0]  exp_addr;
    bit          exp_ready;
    logic [31:0] exp_mask;
  } vec_t;

  vec_t vt[12];

  regfile_wr_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wb_wren_i   (wb_wren),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .ll_valid_i  (ll_valid),
    .ll_ready_o  (ll_ready),
    .ll_addr_i   (ll_addr),
    .ll_data_i   (ll_data),
    .rd_wren_o   (rd_wren),
    .rd_addr_o   (rd_addr),
    .rd_data_o   (rd_data),
    .stall_o     (stall),
    .pend_mask_o (pend_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare the current outputs with the scoreboard, then advance it past the coming edge.
  task automatic checkModel();
    bit          slot_free;
    bit          empty;
    bit          full;
    bit          byp_hit;
    bit          exp_ready;
    bit          pop;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] em;
    int          new_wait;
    slot_free = !(wb_wren && wb_addr != 5'd0);
    empty     = (model_q.size() == 0);
    full      = (model_q.size() == DEPTH);
    byp_hit   = BYP && slot_free && empty && ll_valid && ll_addr != 5'd0;
    exp_ready = !full || (BYP && slot_free);
    ea = 5'd0;
    ed = 32'd0;
    if (!slot_free) begin
      ea = wb_addr; ed = wb_data;
    end else if (!empty) begin
      ea = model_q[0].addr; ed = model_q[0].data;
    end else if (byp_hit) begin
      ea = ll_addr; ed = ll_data;
    end
    em = 32'd0;
    foreach (model_q[k]) em = em | (32'd1 << model_q[k].addr);
    checkOutput("sb rd_wren", {31'd0, rd_wren}, {31'd0, ea != 5'd0});
    if (ea != 5'd0) begin
      checkOutput("sb rd_addr", {27'd0, rd_addr}, {27'd0, ea});
      checkOutput("sb rd_data", rd_data, ed);
    end
    checkOutput("sb ll_ready", {31'd0, ll_ready}, {31'd0, exp_ready});
    checkOutput("sb stall", {31'd0, stall}, {31'd0, model_stall});
    checkOutput("sb pend_mask", pend_mask, em);
    pop      = slot_free && !empty;
    new_wait = (pop || empty) ? 0 : ((model_wait < MAX_WAIT) ? model_wait + 1 : MAX_WAIT);
    if (pop) model_stall = 1'b0;
    else if (new_wait == MAX_WAIT) model_stall = 1'b1;
    model_wait = new_wait;
    if (pop) void'(model_q.pop_front());
    if (ll_valid && exp_ready && ll_addr != 5'd0 && !byp_hit)
      model_q.push_back('{addr: ll_addr, data: ll_data});
  endtask

  task automatic applyStimulus(input bit ww, input logic [4:0] wa, input logic [31:0] wd,
                               input bit lv, input logic [4:0] la, input logic [31:0] ld);
    @(negedge clk);
    wb_wren  = ww;
    wb_addr  = wa;
    wb_data  = wd;
    ll_valid = lv;
    ll_addr  = la;
    ll_data  = ld;
    #1;
    checkModel();
  endtask

  task automatic modelReset();
    model_q.delete();
    model_wait  = 0;
    model_stall = 1'b0;
  endtask

  function automatic vec_t mk(bit ww, logic [4:0] wa, bit lv, logic [4:0] la,
                              bit ew, logic [4:0] ea, bit er, logic [31:0] em);
    vec_t v;
    v.wb_wren = ww;  v.wb_addr = wa;  v.wb_data = 32'h3300_0000 | {27'd0, wa};
    v.ll_valid = lv; v.ll_addr = la;  v.ll_data = 32'h1100_0000 | {27'd0, la};
    v.exp_wren = ew; v.exp_addr = ea; v.exp_ready = er; v.exp_mask = em;
    return v;
  endfunction

  initial begin
    int seen_at;
    bit row_free;

    vt[0]  = mk(1, 5'd3, 1, 5'd1, 1, 5'd3, 1, 32'h0000_0000);
    vt[1]  = mk(1, 5'd3, 1, 5'd2, 1, 5'd3, 1, 32'h0000_0002);
    vt[2]  = mk(1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 32'h0000_0006);
    vt[3]  = mk(1, 5'd3, 1, 5'd4, 1, 5'd3, 1, 32'h0000_000E);
    vt[4]  = mk(1, 5'd3, 1, 5'd5, 1, 5'd3, 0, 32'h0000_001E);
    vt[5]  = mk(0, 5'd0, 0, 5'd0, 1, 5'd1, 0, 32'h0000_001E);
    vt[6]  = mk(1, 5'd3, 1, 5'd5, 1, 5'd3, 1, 32'h0000_001C);
    vt[7]  = mk(0, 5'd0, 0, 5'd0, 1, 5'd2, 0, 32'h0000_003C);
    vt[8]  = mk(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 32'h0000_0038);
    vt[9]  = mk(1, 5'd0, 0, 5'd0, 1, 5'd4, 1, 32'h0000_0030);
    vt[10] = mk(0, 5'd0, 1, 5'd0, 1, 5'd5, 1, 32'h0000_0020);
    vt[11] = mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'h0000_0000);

    rst_n = 1'b0;
    wb_wren = 1'b0; wb_addr = '0; wb_data = '0;
    ll_valid = 1'b0; ll_addr = '0; ll_data = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset rd_wren", {31'd0, rd_wren}, 32'd0);
    checkOutput("reset ll_ready", {31'd0, ll_ready}, 32'd1);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset pend_mask", pend_mask, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table: fill, full back-pressure, drain, x0 handling");
    for (int r = 0; r < 12; r++) begin
      applyStimulus(vt[r].wb_wren, vt[r].wb_addr, vt[r].wb_data,
                    vt[r].ll_valid, vt[r].ll_addr, vt[r].ll_data);
      row_free = !(vt[r].wb_wren && vt[r].wb_addr != 5'd0);
      checkOutput($sformatf("row%0d rd_wren", r), {31'd0, rd_wren}, {31'd0, vt[r].exp_wren});
      if (vt[r].exp_wren)
        checkOutput($sformatf("row%0d rd_addr", r), {27'd0, rd_addr}, {27'd0, vt[r].exp_addr});
      checkOutput($sformatf("row%0d ll_ready", r), {31'd0, ll_ready},
                  {31'd0, vt[r].exp_ready | (BYP & row_free)});
      checkOutput($sformatf("row%0d pend_mask", r), pend_mask, vt[r].exp_mask);
      checkOutput($sformatf("row%0d stall", r), {31'd0, stall}, 32'd0);
    end

    $display("[TB] starvation: WB owns every slot while x7 waits");
    seen_at = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 5'd3, 32'h3333_0000 + i, i == 0, 5'd7, 32'h0000_0077);
      if (stall) begin
        seen_at = i;
        break;
      end
    end
    checkOutput("stall rise cycle", seen_at, MAX_WAIT + 1);
    applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    checkOutput("bubble rd_addr", {27'd0, rd_addr}, 32'd7);
    checkOutput("bubble rd_data", rd_data, 32'h0000_0077);
    checkOutput("bubble stall", {31'd0, stall}, 32'd1);
    applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    checkOutput("post-pop stall", {31'd0, stall}, 32'd0);
    checkOutput("post-pop rd_wren", {31'd0, rd_wren}, 32'd0);

`ifdef REGFILE_ARB_BYPASS_EN
    $display("[TB] bypass: idle slot and empty queue");
    applyStimulus(0, 5'd0, 32'd0, 1, 5'd9, 32'h0000_1234);
    checkOutput("bypass rd_addr", {27'd0, rd_addr}, 32'd9);
    checkOutput("bypass rd_data", rd_data, 32'h0000_1234);
    checkOutput("bypass pend_mask", pend_mask, 32'd0);
    applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    checkOutput("bypass no replay", {31'd0, rd_wren}, 32'd0);
`else
    $display("[TB] single long-latency write with WB idle");
    applyStimulus(0, 5'd0, 32'd0, 1, 5'd5, 32'h0000_00A5);
    checkOutput("ll0 rd_wren", {31'd0, rd_wren}, 32'd0);
    checkOutput("ll0 pend_mask", pend_mask, 32'd0);
    applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    checkOutput("ll1 rd_addr", {27'd0, rd_addr}, 32'd5);
    checkOutput("ll1 rd_data", rd_data, 32'h0000_00A5);
    checkOutput("ll1 pend_mask", pend_mask, 32'h0000_0020);
    applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    checkOutput("ll2 pend_mask", pend_mask, 32'd0);
    checkOutput("ll2 rd_wren", {31'd0, rd_wren}, 32'd0);
`endif

    $display("[TB] async reset with three queued writes and stall high");
    seen_at = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 5'd3, 32'h0000_0300, i < 3, 5'(10 + i), 32'h0000_A000 + i);
      if (stall) begin
        seen_at = i;
        break;
      end
    end
    checkOutput("reset-test stall seen", {31'd0, seen_at >= 0}, 32'd1);
    checkOutput("reset-test pend_mask", pend_mask, 32'h0000_1C00);
    #1;
    wb_wren  = 1'b0;
    ll_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("async rd_wren", {31'd0, rd_wren}, 32'd0);
    checkOutput("async ll_ready", {31'd0, ll_ready}, 32'd1);
    checkOutput("async stall", {31'd0, stall}, 32'd0);
    checkOutput("async pend_mask", pend_mask, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput($sformatf("after reset %0d rd_wren", i), {31'd0, rd_wren}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
